// File: rtl/regfile_decoded_pkg.sv
// Shared defaults and types for the integer register file slice.
package regfile_decoded_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int REG_ZERO     = 0;

  typedef logic [REG_ADDR_W-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xlen_t;

endpackage

// File: rtl/regfile_decoded_decoder_n.sv
// Parametrised N-to-2**N one-hot decoder; all outputs low when EN is low.
module decoder_n
  import regfile_decoded_pkg::*;
#(
  parameter int N = REG_ADDR_W
) (
  input  logic [N-1:0]      IN,
  input  logic              EN,
  output logic [2**N-1:0]   OUT
);

  always_comb begin
    OUT = '0;
    if (EN) OUT[IN] = 1'b1;
  end

endmodule

// File: rtl/regfile_decoded.sv
// Integer register file: one synchronous write port, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_decoded
  import regfile_decoded_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 WE,
  input  logic [ADDR_W-1:0]    RD_ADDR,
  input  logic [XLEN-1:0]      WR_DATA,
  input  logic [ADDR_W-1:0]    RS1_ADDR,
  input  logic [ADDR_W-1:0]    RS2_ADDR,
  output logic [XLEN-1:0]      RS1_DATA,
  output logic [XLEN-1:0]      RS2_DATA,
  output logic [2**ADDR_W-1:0] WE_ONEHOT
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] dec;
  logic             dec_en;

  // Reset gates the strobe so a write coinciding with reset is dropped.
  assign dec_en = WE && !RST;

  decoder_n #(.N(ADDR_W)) u_dec (
    .IN  (RD_ADDR),
    .EN  (dec_en),
    .OUT (dec)
  );

  always_comb begin
    WE_ONEHOT = dec;
    if (ZERO_REG != 0) WE_ONEHOT[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[ADDR_W'(i)] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++)
        if (WE_ONEHOT[ADDR_W'(i)]) regs[ADDR_W'(i)] <= WR_DATA;
    end
  end

  // The masked strobe already encodes WE, !RST and the hardwired-zero rule,
  // so it doubles as the per-port forwarding condition.
  always_comb begin
    RS1_DATA = regs[RS1_ADDR];
    RS2_DATA = regs[RS2_ADDR];
    if (ZERO_REG != 0 && RS1_ADDR == '0) RS1_DATA = '0;
    if (ZERO_REG != 0 && RS2_ADDR == '0) RS2_DATA = '0;
`ifdef REGFILE_BYPASS_EN
    if (WE_ONEHOT[RS1_ADDR]) RS1_DATA = WR_DATA;
    if (WE_ONEHOT[RS2_ADDR]) RS2_DATA = WR_DATA;
`else
`endif
  end

endmodule
